// File: rtl/cmp_pkg.sv
// Shared types for the branch/SLT comparison arbiter: funct3 encodings, response record, port count.
package cmp_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'b000,
    CMP_NE  = 3'b001,
    CMP_LT  = 3'b100,
    CMP_GE  = 3'b101,
    CMP_LTU = 3'b110,
    CMP_GEU = 3'b111
  } cmp_op_e;

  typedef struct packed {
    logic port;
    logic result;
    logic less;
    logic equal;
    logic err;
  } cmp_rsp_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/cmp_core.sv
// Combinational N-bit signed/unsigned compare; zero latency, no flow control.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   op_i,
  input  logic [N-1:0] rs1_i,
  input  logic [N-1:0] rs2_i,
  output logic         result_o,
  output logic         less_o,
  output logic         equal_o,
  output logic         err_o
);

  logic [N:0] a_ext, b_ext, diff;
  logic       lt, eq;

  always_comb begin
    // One extra bit makes the borrow of rs1-rs2 the less-than flag for both signednesses.
    a_ext = {(~op_i[1] & rs1_i[N-1]), rs1_i};
    b_ext = {(~op_i[1] & rs2_i[N-1]), rs2_i};
    diff  = a_ext - b_ext;
    lt    = diff[N];
    eq    = (rs1_i == rs2_i);

    result_o = 1'b0;
    less_o   = lt;
    equal_o  = eq;
    err_o    = 1'b0;
    unique case (op_i)
      CMP_EQ:           result_o = eq;
      CMP_NE:           result_o = ~eq;
      CMP_LT, CMP_LTU:  result_o = lt;
      CMP_GE, CMP_GEU:  result_o = ~lt;
      default: begin
        less_o  = 1'b0;
        equal_o = 1'b0;
        err_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin shared compare stage for branch (port 0) and SLT (port 1); one-cycle latency.
// Single-entry response buffer: accepts while empty or draining, flush drops the entry and blocks accept.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [3*NUM_REQ-1:0]   req_op_i,
  input  logic [N*NUM_REQ-1:0]   req_rs1_i,
  input  logic [N*NUM_REQ-1:0]   req_rs2_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_port_o,
  output logic                   rsp_result_o,
  output logic                   rsp_less_o,
  output logic                   rsp_equal_o,
  output logic                   rsp_err_o
);

  rsp_state_e state_q, state_d;
  cmp_rsp_t   rsp_q, rsp_d;
  logic       rr_last_q, rr_last_d;

  logic       cand, slot_free, accept;
  logic [2:0] sel_op;
  logic [N-1:0] sel_rs1, sel_rs2;
  logic       c_result, c_less, c_equal, c_err;

  always_comb begin
    unique case (req_valid_i)
      2'b01:   cand = 1'b0;
      2'b10:   cand = 1'b1;
      2'b11:   cand = ~rr_last_q;
      default: cand = 1'b0;
    endcase

    sel_op  = cand ? req_op_i[5:3]         : req_op_i[2:0];
    sel_rs1 = cand ? req_rs1_i[2*N-1:N]    : req_rs1_i[N-1:0];
    sel_rs2 = cand ? req_rs2_i[2*N-1:N]    : req_rs2_i[N-1:0];

    slot_free   = (state_q == ST_EMPTY) | rsp_ready_i;
    req_ready_o = {cand, ~cand} & req_valid_i & {NUM_REQ{slot_free & ~flush_i}};
    accept      = |req_ready_o;
  end

  cmp_core #(.N(N)) u_core (
    .op_i     (sel_op),
    .rs1_i    (sel_rs1),
    .rs2_i    (sel_rs2),
    .result_o (c_result),
    .less_o   (c_less),
    .equal_o  (c_equal),
    .err_o    (c_err)
  );

  // Flush outranks both accept and drain; the arbitration pointer survives a flush.
  always_comb begin
    state_d   = state_q;
    rsp_d     = rsp_q;
    rr_last_d = rr_last_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d   = ST_FULL;
      rsp_d     = '{port: cand, result: c_result, less: c_less, equal: c_equal, err: c_err};
      rr_last_d = cand;
    end else if (rsp_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_EMPTY;
      rsp_q     <= '0;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rsp_q     <= rsp_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign rsp_valid_o  = (state_q == ST_FULL);
  assign rsp_port_o   = rsp_q.port;
  assign rsp_result_o = rsp_q.result;
  assign rsp_less_o   = rsp_q.less;
  assign rsp_equal_o  = rsp_q.equal;
  assign rsp_err_o    = rsp_q.err;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_cmp_arbiter;

  localparam int N = 32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [5:0]  req_op_i;
  logic [63:0] req_rs1_i, req_rs2_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_port_o;
  logic        rsp_result_o, rsp_less_o, rsp_equal_o, rsp_err_o;

  logic [2:0]   op  [2];
  logic [N-1:0] ra  [2];
  logic [N-1:0] rb  [2];

  assign req_op_i  = {op[1], op[0]};
  assign req_rs1_i = {ra[1], ra[0]};
  assign req_rs2_i = {rb[1], rb[0]};

  always #5 clk_i = ~clk_i;

  cmp_arbiter #(.N(N)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_rs1_i    (req_rs1_i),
    .req_rs2_i    (req_rs2_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_port_o   (rsp_port_o),
    .rsp_result_o (rsp_result_o),
    .rsp_less_o   (rsp_less_o),
    .rsp_equal_o  (rsp_equal_o),
    .rsp_err_o    (rsp_err_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: buffer occupancy, buffered fields, last granted port.
  bit m_full, m_last, m_port, m_res, m_less, m_eq, m_err;
  int grants[$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Returns {err, result, less, equal} straight from the funct3 meaning.
  function automatic logic [3:0] ref_cmp(logic [2:0] f3, logic [N-1:0] a, logic [N-1:0] b);
    logic lt_s, lt_u, eq;
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    eq   = (a == b);
    case (f3)
      3'b000:  return {1'b0, eq,    lt_s, eq};
      3'b001:  return {1'b0, ~eq,   lt_s, eq};
      3'b100:  return {1'b0, lt_s,  lt_s, eq};
      3'b101:  return {1'b0, ~lt_s, lt_s, eq};
      3'b110:  return {1'b0, lt_u,  lt_u, eq};
      3'b111:  return {1'b0, ~lt_u, lt_u, eq};
      default: return 4'b1000;
    endcase
  endfunction

  task automatic model_reset();
    m_full = 0; m_last = 1;
    m_port = 0; m_res = 0; m_less = 0; m_eq = 0; m_err = 0;
  endtask

  task automatic drive(logic [1:0] v, logic [2:0] o0, logic [N-1:0] a0, logic [N-1:0] b0,
                       logic [2:0] o1, logic [N-1:0] a1, logic [N-1:0] b1, logic rdy, logic fl);
    req_valid_i = v;
    op[0] = o0; ra[0] = a0; rb[0] = b0;
    op[1] = o1; ra[1] = a1; rb[1] = b1;
    rsp_ready_i = rdy;
    flush_i = fl;
  endtask

  // One clock: check ready mid-cycle, advance the model, check the registered response.
  task automatic tick();
    logic [1:0] v, exp_rdy;
    bit slot, cand, nfull;
    logic [3:0] r;
    @(negedge clk_i);
    v = req_valid_i;
    slot = !m_full || rsp_ready_i;
    cand = (v == 2'b11) ? !m_last : (v == 2'b10);
    exp_rdy = 2'b00;
    if (v != 2'b00 && slot && !flush_i) exp_rdy[cand] = 1'b1;
    chk("req_ready", req_ready_o, exp_rdy);
    if (req_ready_o == 2'b01) grants.push_back(0);
    if (req_ready_o == 2'b10) grants.push_back(1);
    nfull = m_full;
    if (flush_i) nfull = 0;
    else if (exp_rdy != 2'b00) begin
      r = ref_cmp(op[cand], ra[cand], rb[cand]);
      nfull = 1; m_port = cand; m_last = cand;
      {m_err, m_res, m_less, m_eq} = r;
    end else if (rsp_ready_i) nfull = 0;
    @(posedge clk_i);
    #1;
    m_full = nfull;
    chk("rsp_valid", rsp_valid_o, m_full);
    if (m_full) begin
      chk("rsp_port", rsp_port_o, m_port);
      chk("rsp_result", rsp_result_o, m_res);
      chk("rsp_less", rsp_less_o, m_less);
      chk("rsp_equal", rsp_equal_o, m_eq);
      chk("rsp_err", rsp_err_o, m_err);
    end
  endtask

  function automatic logic [N-1:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_i = 1'b1;
    drive(2'b00, 3'b000, 0, 0, 3'b000, 0, 0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rst_valid", rsp_valid_o, 0);
    chk("rst_port", rsp_port_o, 0);
    chk("rst_result", rsp_result_o, 0);
    chk("rst_less", rsp_less_o, 0);
    chk("rst_equal", rsp_equal_o, 0);
    chk("rst_err", rsp_err_o, 0);

    // Signed vs unsigned on -1 vs 1
    drive(2'b01, 3'b100, 32'hFFFF_FFFF, 32'h1, 3'b000, 0, 0, 1'b1, 1'b0);
    tick();
    chk("lt_valid", rsp_valid_o, 1);
    chk("lt_port", rsp_port_o, 0);
    chk("lt_result", rsp_result_o, 1);
    chk("lt_less", rsp_less_o, 1);
    chk("lt_equal", rsp_equal_o, 0);
    drive(2'b01, 3'b110, 32'hFFFF_FFFF, 32'h1, 3'b000, 0, 0, 1'b1, 1'b0);
    tick();
    chk("ltu_result", rsp_result_o, 0);

    // Equality and invalid op
    drive(2'b01, 3'b000, 32'h8000_0000, 32'h8000_0000, 3'b000, 0, 0, 1'b1, 1'b0);
    tick();
    chk("eq_result", rsp_result_o, 1);
    chk("eq_equal", rsp_equal_o, 1);
    drive(2'b01, 3'b001, 32'h8000_0000, 32'h8000_0000, 3'b000, 0, 0, 1'b1, 1'b0);
    tick();
    chk("ne_result", rsp_result_o, 0);
    chk("ne_equal", rsp_equal_o, 1);
    drive(2'b01, 3'b010, 32'h8000_0000, 32'h8000_0000, 3'b000, 0, 0, 1'b1, 1'b0);
    tick();
    chk("inv_err", rsp_err_o, 1);
    chk("inv_result", rsp_result_o, 0);

    // Contention: last grant was port 0, so this run starts on 1; realign first
    drive(2'b10, 3'b000, 0, 0, 3'b100, 5, 7, 1'b1, 1'b0);
    tick();
    grants.delete();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 3'b100, i, 3, 3'b110, 3, i, 1'b1, 1'b0);
      tick();
    end
    chk("grant_cnt", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk("grant_seq", grants[i], i % 2);

    // Back-pressure: hold consumer off for 3 cycles, then drain + accept together
    drive(2'b11, 3'b101, 10, 20, 3'b111, 30, 40, 1'b0, 1'b0);
    repeat (3) tick();
    chk("bp_ready", req_ready_o, 2'b00);
    rsp_ready_i = 1'b1;
    tick();
    chk("bp_refill", rsp_valid_o, 1);

    // Flush while full with port 1 pending
    drive(2'b10, 3'b000, 0, 0, 3'b100, 1, 2, 1'b0, 1'b0);
    tick();
    flush_i = 1'b1;
    tick();
    chk("flush_empty", rsp_valid_o, 0);
    flush_i = 1'b0;
    tick();
    chk("flush_next_port", rsp_port_o, 1);

    // Asynchronous reset while full
    drive(2'b01, 3'b100, 1, 2, 3'b000, 0, 0, 1'b0, 1'b0);
    tick();
    #2 rst_i = 1'b1;
    #1;
    chk("arst_valid", rsp_valid_o, 0);
    chk("arst_result", rsp_result_o, 0);
    model_reset();
    req_valid_i = 2'b00;
    @(negedge clk_i) rst_i = 1'b0;
    @(posedge clk_i); #1;
    grants.delete();
    drive(2'b11, 3'b000, 4, 4, 3'b000, 5, 6, 1'b1, 1'b0);
    tick();
    chk("arst_tie_cnt", grants.size(), 1);
    if (grants.size() > 0) chk("arst_tie_port0", grants[0], 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      req_valid_i = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        op[p] = 3'($urandom_range(0, 7));
        ra[p] = pick_val();
        rb[p] = ($urandom_range(0, 4) == 0) ? ra[p] : pick_val();
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
